if_pc_gen: RTL and testbench

- Parametrised fetch-stage program-counter generator; successor to the fixed 32-bit PC register in the IF stage.
- Drives the instruction-memory address and PC+INC to the decode pipeline register.
- Adds a configurable reset vector and a boot hold-off.
- Handles redirects (branch/jump/flush) with stall-safe capture, reports misaligned redirect targets, and counts advanced fetches.

---
 rtl/if_pc_gen.sv | 137 +++++++++++++
 tb/tb_if_pc_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// Fetch-stage program-counter generator.
// Produces the instruction-memory address and its sequential successor, holds
// fetch off for a few cycles after reset, captures redirects safely across
// stalls, flags misaligned redirect targets and counts advanced fetches.

module if_pc_gen #(
   parameter int unsigned          XLEN        = 32,
   parameter logic [XLEN-1:0]      RESET_VEC   = '0,
   parameter int unsigned          INC         = 4,
   parameter int unsigned          ALIGN_BITS  = 2,
   parameter int unsigned          BOOT_CYCLES = 1,
   parameter int unsigned          CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_redirect,
   input  logic [XLEN-1:0]  i_redirect_pc,
   output logic [XLEN-1:0]  o_pc,
   output logic [XLEN-1:0]  o_inc_pc,
   output logic             o_valid,
   output logic             o_misaligned,
   output logic [CNT_W-1:0] o_fetch_cnt
);

   localparam int unsigned     BW       = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam logic [BW-1:0]   BOOT_INIT = BW'(BOOT_CYCLES);
   localparam logic [BW-1:0]   BOOT_ONE  = BW'(1);
   localparam logic [XLEN-1:0] INC_V     = XLEN'(INC);

   // BOOT: hold-off after reset; RUN: fetching on the correct path;
   // PEND: a redirect arrived during a stall and waits for the pipe to advance.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t           state_q, state_nxt;
   logic [XLEN-1:0]  pc_q, pc_nxt;
   logic [XLEN-1:0]  pend_pc_q, pend_pc_nxt;
   logic             pend_flag_q, pend_flag_nxt;
   logic [BW-1:0]    boot_cnt_q, boot_cnt_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             valid_q;
   logic             mis_q, mis_nxt;

   // Next-state, next-PC and bookkeeping for every register in the block.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_nxt     = state_q;
      pc_nxt        = pc_q;
      pend_pc_nxt   = pend_pc_q;
      pend_flag_nxt = pend_flag_q;
      boot_cnt_nxt  = boot_cnt_q;
      cnt_nxt       = cnt_q;
      // Every redirect is accepted in every state (loaded or captured), so
      // the alignment flag only depends on the request itself.
      mis_nxt       = i_redirect && (i_redirect_pc[ALIGN_BITS-1:0] != '0);

      unique case (state_q)
         ST_BOOT: begin
            boot_cnt_nxt = boot_cnt_q - BOOT_ONE;
            if (i_redirect) begin
               pend_pc_nxt   = i_redirect_pc;
               pend_flag_nxt = 1'b1;
            end
            if (boot_cnt_q <= BOOT_ONE) begin
               state_nxt     = ST_RUN;
               pend_flag_nxt = 1'b0;
               // A redirect on the final boot edge is the youngest target.
               if (i_redirect)       pc_nxt = i_redirect_pc;
               else if (pend_flag_q) pc_nxt = pend_pc_q;
            end
         end

         ST_RUN: begin
            if (i_redirect) begin
               if (i_en) begin
                  pc_nxt = i_redirect_pc;
               end else begin
                  pend_pc_nxt = i_redirect_pc;
                  state_nxt   = ST_PEND;
               end
            end else if (i_en) begin
               pc_nxt  = pc_q + INC_V;
               cnt_nxt = cnt_q + 1'b1;
            end
         end

         ST_PEND: begin
            if (i_redirect) pend_pc_nxt = i_redirect_pc;
            if (i_en) begin
               pc_nxt    = i_redirect ? i_redirect_pc : pend_pc_q;
               state_nxt = ST_RUN;
            end
         end

         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   // State register with synchronous active-low reset overriding all inputs.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      if (!i_rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_VEC;
         pend_pc_q   <= '0;
         pend_flag_q <= 1'b0;
         boot_cnt_q  <= BOOT_INIT;
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         pc_q        <= pc_nxt;
         pend_pc_q   <= pend_pc_nxt;
         pend_flag_q <= pend_flag_nxt;
         boot_cnt_q  <= boot_cnt_nxt;
         cnt_q       <= cnt_nxt;
         valid_q     <= (state_nxt == ST_RUN);
         mis_q       <= mis_nxt;
      end
   end

   assign o_pc         = pc_q;
   assign o_inc_pc     = pc_q + INC_V;
   assign o_valid      = valid_q;
   assign o_misaligned = mis_q;
   assign o_fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// Testbench for if_pc_gen: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the fetch PC rules.

module tb_if_pc_gen;

   localparam int unsigned XLEN        = 32;
   localparam logic [31:0] RESET_VEC   = 32'h0000_0100;
   localparam int unsigned INC         = 4;
   localparam int unsigned ALIGN_BITS  = 2;
   localparam int unsigned BOOT_CYCLES = 1;
   localparam int unsigned CNT_W       = 32;
   localparam logic [31:0] ALIGN_MASK  = (32'd1 << ALIGN_BITS) - 32'd1;

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic             i_en;
   logic             i_redirect;
   logic [XLEN-1:0]  i_redirect_pc;
   logic [XLEN-1:0]  o_pc;
   logic [XLEN-1:0]  o_inc_pc;
   logic             o_valid;
   logic             o_misaligned;
   logic [CNT_W-1:0] o_fetch_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the PC plus a few facts about where fetch stands.
   typedef enum int {M_BOOT, M_RUN, M_PEND} mode_t;
   mode_t       m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_pend_pc;
   logic        m_have_pend;
   int          m_boot_left;
   logic        m_mis;
   logic [31:0] m_cnt;

   if_pc_gen #(
      .XLEN(XLEN), .RESET_VEC(RESET_VEC), .INC(INC),
      .ALIGN_BITS(ALIGN_BITS), .BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_pc(o_pc), .o_inc_pc(o_inc_pc), .o_valid(o_valid),
      .o_misaligned(o_misaligned), .o_fetch_cnt(o_fetch_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic rst_n, input logic en, input logic redir,
                             input logic [31:0] tgt);
      if (!rst_n) begin
         m_mode = M_BOOT; m_pc = RESET_VEC; m_pend_pc = 0; m_have_pend = 1'b0;
         m_boot_left = BOOT_CYCLES; m_mis = 1'b0; m_cnt = 0;
         return;
      end
      m_mis = redir && ((tgt & ALIGN_MASK) != 0);
      case (m_mode)
         M_BOOT: begin
            if (redir) begin m_pend_pc = tgt; m_have_pend = 1'b1; end
            m_boot_left = m_boot_left - 1;
            if (m_boot_left == 0) begin
               m_mode = M_RUN;
               if (m_have_pend) m_pc = m_pend_pc;
               m_have_pend = 1'b0;
            end
         end
         M_RUN: begin
            if (redir && en)      m_pc = tgt;
            else if (redir)       begin m_pend_pc = tgt; m_mode = M_PEND; end
            else if (en)          begin m_pc = m_pc + INC; m_cnt = m_cnt + 1; end
         end
         default: begin
            if (redir) m_pend_pc = tgt;
            if (en) begin m_pc = m_pend_pc; m_mode = M_RUN; end
         end
      endcase
   endtask

   // Apply one cycle of inputs, then compare every output at the falling edge.
   task automatic step(input logic rst_n, input logic en, input logic redir,
                       input logic [31:0] tgt);
      i_rst_n = rst_n; i_en = en; i_redirect = redir; i_redirect_pc = tgt;
      @(posedge i_clk);
      model_edge(rst_n, en, redir, tgt);
      @(negedge i_clk);
      check("pc",         o_pc,                m_pc);
      check("inc_pc",     o_inc_pc,            m_pc + INC);
      check("valid",      {31'b0, o_valid},    {31'b0, m_mode == M_RUN});
      check("misaligned", {31'b0, o_misaligned}, {31'b0, m_mis});
      check("fetch_cnt",  o_fetch_cnt,         m_cnt);
   endtask

   initial begin
      logic [31:0] tgt;
      logic        rn, en, rd;
      i_rst_n = 1'b0; i_en = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
      @(negedge i_clk);

      // Reset for two edges, then release with the pipe advancing.
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("rst_pc",    o_pc, 32'h100);
      check("rst_valid", {31'b0, o_valid}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("boot_done_pc", o_pc, 32'h100);
      check("boot_done_valid", {31'b0, o_valid}, 32'h1);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("seq1_pc", o_pc, 32'h104);
      check("seq1_cnt", o_fetch_cnt, 32'd1);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("seq2_pc", o_pc, 32'h108);

      // Redirect while advancing: counter must not move on the redirect edge.
      step(1'b1, 1'b1, 1'b1, 32'h200);
      step(1'b1, 1'b1, 1'b1, 32'h40);
      check("redir_pc", o_pc, 32'h40);
      check("redir_cnt", o_fetch_cnt, 32'd2);

      // Redirects during a stall: youngest wins once the pipe advances.
      step(1'b1, 1'b1, 1'b1, 32'h300);
      step(1'b1, 1'b0, 1'b1, 32'h80);
      check("stall_pc", o_pc, 32'h300);
      check("stall_valid", {31'b0, o_valid}, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h90);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("release_pc", o_pc, 32'h90);

      // Misaligned target pulses the flag for one cycle; aligned does not.
      step(1'b1, 1'b1, 1'b1, 32'h102);
      check("mis_pulse", {31'b0, o_misaligned}, 32'h1);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("mis_drop", {31'b0, o_misaligned}, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h104);

      // Wrap-around at the top of the address space.
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("wrap_pc", o_pc, 32'h0);
      check("wrap_inc", o_inc_pc, 32'h4);

      // Reset while a redirect is pending discards the pending target.
      step(1'b1, 1'b0, 1'b1, 32'h500);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("post_rst_pc", o_pc, 32'h104);

      // Random traffic, including occasional resets and redirects at boot.
      for (int i = 0; i < 400; i++) begin
         rn  = ($urandom_range(0, 39) != 0);
         en  = ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 4) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 1) == 1) tgt = tgt & ~ALIGN_MASK;
         step(rn, en, rd, tgt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
